alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator side of the 64-bit ALU operand/op_code interface. Accepts ALU commands over a
//  valid/ready stream, registers them onto the ALU input bus, tracks each op through the ALU's
//  fixed output-register latency, captures O/overflow with the command's tag, and returns
//  results in order over a back-pressurable response stream. Sits between a host/test
//  controller and the ALU instance; top level ties ALU rst_n = ~rst.
// PARAMETERS
//  TAG_W      4   width of command/response tag
//  RSP_DEPTH  4   response FIFO entries; power of 2, >= 2
//  ALU_LAT    1   ALU cycles from input bus to registered O (fixed at 1 for current ALU)
// PORTS
//  clk            in   1      single clock; all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  cmd_valid      in   1      command present
//  cmd_ready      out  1      sequencer accepts command this cycle
//  cmd_op         in   4      ALU op_code
//  cmd_a, cmd_b   in   64     operands
//  cmd_shamt      in   6      shift amount
//  cmd_sub_start  in   6      substring start bit
//  cmd_sub_len    in   6      substring length
//  cmd_tag        in   TAG_W  returned unchanged with result
//  alu_a, alu_b   out  64     to ALU A/B (registered)
//  alu_op_code    out  4      to ALU op_code (registered)
//  alu_shift_amt, alu_sub_start, alu_sub_len  out 6 each, registered
//  alu_o          in   64     ALU O
//  alu_overflow   in   1      ALU overflow
//  rsp_valid      out  1      response at FIFO head
//  rsp_ready      in   1      consumer takes response
//  rsp_result     out  64     captured O (0 when rsp_err)
//  rsp_overflow   out  1      captured overflow (0 when rsp_err)
//  rsp_err        out  1      op_code 4'b1011..4'b1111 (unsupported)
//  rsp_tag        out  TAG_W  tag of this response
//  busy           out  1      any op in flight or FIFO non-empty
//  ops_done       out  32     responses popped since reset, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset (sync, rst=1): all alu_* = 0, cmd_ready=0, rsp_valid=0, FIFO empty, in-flight pipe
//    cleared (ops in flight discarded, never returned), ops_done=0, busy=0.
//  - Credit: cmd_ready = !rst && (fifo_count + inflight_count < RSP_DEPTH), from registered
//    state only; no combinational path rsp_ready -> cmd_ready. FIFO can never overflow.
//  - Accept at edge t0 (cmd_valid & cmd_ready): alu_* load cmd fields; stage0 valid+tag+err set.
//    Pipe of ALU_LAT+1 stages shifts every cycle; at edge t0+ALU_LAT+1 (t0+2) last stage pushes
//    {alu_o, alu_overflow, tag, err} into FIFO. Accept-to-rsp_valid latency = 2 cycles when FIFO
//    empty. Full throughput: one accept per cycle while credit remains.
//  - No accept: alu_* hold previous values; no pipe entry created.
//  - Illegal op: still issued to ALU, occupies a slot; response has rsp_err=1, result/overflow 0.
//  - Response: rsp_* show FIFO head while rsp_valid; pop on rsp_valid & rsp_ready; payload stable
//    while rsp_valid & !rsp_ready. ops_done increments on each pop.
//  - Simultaneous push and pop: both occur, count unchanged; push into empty FIFO with no pop
//    makes rsp_valid=1 next cycle (no bypass).
//  - Pop frees credit visible to cmd_ready the following cycle.
//  - Strict in-order: responses in accept order.
//  - busy = |pipe_valid | (fifo_count != 0).
// STRUCTURE
//  - Shared header alu_g13_defs.vh: op_code localparams OP_ADD=0000, OP_SUB=0001, OP_AND=0010,
//    OP_OR=0011, OP_XNOR=0100, OP_GT=0101, OP_SHL=0110, OP_SHR=0111, OP_SUBSTR=1000,
//    OP_SHRGT=1001, OP_SHLGT=1010, OP_LAST=1010; also used by the ALU and benches.
//  - One sub-module: alu_rsp_fifo (sync FIFO, width 64+1+1+TAG_W, depth RSP_DEPTH, count out).
//  - Top: issue regs, in-flight shift pipe, credit logic, ops_done counter.
// TESTING (bench instantiates the ALU with rst_n=~rst)
//  1 ADD A=64'hFFFF_FFFF_FFFF_FFFF, B=1, tag=3, rsp_ready=1 -> rsp_valid 2 cycles after
//    accept; result=0, overflow=1, tag=3, err=0; ops_done=1 after pop.
//  2 Back-to-back SUB 5-3, GT 7>2, SHL 1<<63, SUBSTR A=B=0xAB start=4 len=4 -> 4 responses
//    consecutive cycles: 2, 1, 64'h8000_0000_0000_0000, 1; tags in order.
//  3 rsp_ready=0, cmd_valid held -> exactly RSP_DEPTH(4) accepts, cmd_ready=0 after; release
//    rsp_ready -> 4 pops, cmd_ready returns cycle after first pop; no loss/duplication.
//  4 op=4'b1100, A=B=1 -> rsp_err=1, result=0, overflow=0; next OR 0xF0|0x0F -> 0xFF, err=0.
//  5 Assert rst one cycle with 2 ops in flight and 1 in FIFO -> next cycle rsp_valid=0, busy=0,
//    alu_*=0, ops_done=0; after release, new XNOR 0,0 -> 64'hFFFF_FFFF_FFFF_FFFF, no stale rsp.
//  6 Random ops vs reference model, random rsp_ready 50% -> all results/tags match, in order.

Source files
------------

// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared op_code encodings and helpers for the ALU command sequencer and its benches.
package alu_cmd_sequencer_pkg;

    localparam int DATA_W  = 64;
    localparam int SHAMT_W = 6;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_AND    = 4'b0010;
    localparam logic [3:0] OP_OR     = 4'b0011;
    localparam logic [3:0] OP_XNOR   = 4'b0100;
    localparam logic [3:0] OP_GT     = 4'b0101;
    localparam logic [3:0] OP_SHL    = 4'b0110;
    localparam logic [3:0] OP_SHR    = 4'b0111;
    localparam logic [3:0] OP_SUBSTR = 4'b1000;
    localparam logic [3:0] OP_SHRGT  = 4'b1001;
    localparam logic [3:0] OP_SHLGT  = 4'b1010;
    localparam logic [3:0] OP_LAST   = 4'b1010;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > OP_LAST;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head entry is presented combinationally.
module alu_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues ALU commands, tracks them through the ALU output register, and returns
// results in accept order through a credit-protected response FIFO.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_op,
    input  logic [63:0]        cmd_a,
    input  logic [63:0]        cmd_b,
    input  logic [5:0]         cmd_shamt,
    input  logic [5:0]         cmd_sub_start,
    input  logic [5:0]         cmd_sub_len,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [63:0]        alu_a,
    output logic [63:0]        alu_b,
    output logic [3:0]         alu_op_code,
    output logic [5:0]         alu_shift_amt,
    output logic [5:0]         alu_sub_start,
    output logic [5:0]         alu_sub_len,
    input  logic [63:0]        alu_o,
    input  logic               alu_overflow,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_result,
    output logic               rsp_overflow,
    output logic               rsp_err,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic               busy,
    output logic [31:0]        ops_done
);
    localparam int RSP_W = DATA_W + 2 + TAG_W;
    localparam int FCW   = $clog2(RSP_DEPTH) + 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + ALU_LAT + 2) + 1;

    logic [ALU_LAT:0]  vld_p;
    logic [TAG_W-1:0]  tag_p [ALU_LAT+1];
    logic              err_p [ALU_LAT+1];

    logic              accept;
    logic              pop;
    logic [FCW-1:0]    fifo_count;
    logic [CNT_W-1:0]  inflight_cnt;
    logic [RSP_W-1:0]  push_data;
    logic [RSP_W-1:0]  pop_data;
    logic              last_err;

    // Credit counts both queued responses and ops still travelling to the FIFO.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= ALU_LAT; i++) inflight_cnt = inflight_cnt + CNT_W'(vld_p[i]);
    end

    assign cmd_ready = !rst && ((CNT_W'(fifo_count) + inflight_cnt) < CNT_W'(RSP_DEPTH));
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (|vld_p) || (fifo_count != '0);

    // Issue stage: ALU input bus holds its value until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op_code   <= '0;
            alu_shift_amt <= '0;
            alu_sub_start <= '0;
            alu_sub_len   <= '0;
        end else if (accept) begin
            alu_a         <= cmd_a;
            alu_b         <= cmd_b;
            alu_op_code   <= cmd_op;
            alu_shift_amt <= cmd_shamt;
            alu_sub_start <= cmd_sub_start;
            alu_sub_len   <= cmd_sub_len;
        end
    end

    // In-flight pipe: stage ALU_LAT lines up with the ALU's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= accept;
            for (int i = 1; i <= ALU_LAT; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_p[0] <= cmd_tag;
        err_p[0] <= op_is_illegal(cmd_op);
        for (int i = 1; i <= ALU_LAT; i++) begin
            tag_p[i] <= tag_p[i-1];
            err_p[i] <= err_p[i-1];
        end
    end

    assign last_err  = err_p[ALU_LAT];
    assign push_data = {last_err ? '0 : alu_o, last_err ? 1'b0 : alu_overflow,
                        tag_p[ALU_LAT], last_err};

    alu_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p[ALU_LAT]),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (fifo_count)
    );

    assign rsp_result   = pop_data[RSP_W-1 -: DATA_W];
    assign rsp_overflow = pop_data[TAG_W+1];
    assign rsp_tag      = pop_data[TAG_W:1];
    assign rsp_err      = pop_data[0];

    always_ff @(posedge clk) begin
        if (rst)      ops_done <= '0;
        else if (pop) ops_done <= ops_done + 32'd1;
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU attached to its bus.
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [3:0]        cmd_op = '0;
    logic [63:0]       cmd_a = '0, cmd_b = '0;
    logic [5:0]        cmd_shamt = '0, cmd_sub_start = '0, cmd_sub_len = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic [63:0]       alu_a, alu_b;
    logic [3:0]        alu_op_code;
    logic [5:0]        alu_shift_amt, alu_sub_start, alu_sub_len;
    logic [63:0]       alu_o;
    logic              alu_overflow;
    logic              alu_rst_n;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [63:0]       rsp_result;
    logic              rsp_overflow, rsp_err;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    logic [31:0]       ops_done;

    typedef struct {
        logic [63:0]      res;
        logic             ov;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_ops = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.TAG_W(TAG_W), .RSP_DEPTH(4), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
        .cmd_sub_start(cmd_sub_start), .cmd_sub_len(cmd_sub_len), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
        .alu_shift_amt(alu_shift_amt), .alu_sub_start(alu_sub_start),
        .alu_sub_len(alu_sub_len), .alu_o(alu_o), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
        .busy(busy), .ops_done(ops_done)
    );

    // Returns {overflow, result}; unsupported codes give garbage the sequencer must mask.
    function automatic logic [64:0] alu_fn(input logic [3:0] op, input logic [63:0] a,
                                           input logic [63:0] b, input logic [5:0] sh,
                                           input logic [5:0] st, input logic [5:0] len);
        logic [63:0] mask;
        mask = (len == 6'd0) ? 64'd0 : (~64'd0 >> (64 - int'(len)));
        case (op)
            OP_ADD:    return {1'b0, a} + {1'b0, b};
            OP_SUB:    return {(a < b), a - b};
            OP_AND:    return {1'b0, a & b};
            OP_OR:     return {1'b0, a | b};
            OP_XNOR:   return {1'b0, ~(a ^ b)};
            OP_GT:     return {1'b0, 63'd0, (a > b)};
            OP_SHL:    return {1'b0, a << sh};
            OP_SHR:    return {1'b0, a >> sh};
            OP_SUBSTR: return {1'b0, 63'd0, (((a >> st) & mask) == ((b >> st) & mask))};
            OP_SHRGT:  return {1'b0, 63'd0, ((a >> sh) > b)};
            OP_SHLGT:  return {1'b0, 63'd0, ((a << sh) > b)};
            default:   return {1'b1, 64'hDEAD_BEEF_0BAD_F00D};
        endcase
    endfunction

    assign alu_rst_n = ~rst;

    always_ff @(posedge clk) begin
        if (!alu_rst_n) {alu_overflow, alu_o} <= '0;
        else {alu_overflow, alu_o} <= alu_fn(alu_op_code, alu_a, alu_b, alu_shift_amt,
                                             alu_sub_start, alu_sub_len);
    end

    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [5:0] sh, input logic [5:0] st,
                                   input logic [5:0] len, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [64:0] r;
        e.tag = tag;
        e.err = (op >= 4'b1011);
        r = alu_fn(op, a, b, sh, st, len);
        e.res = e.err ? 64'd0 : r[63:0];
        e.ov  = e.err ? 1'b0 : r[64];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: record accepted commands, compare every popped response in order.
    initial begin
        exp_t        e;
        logic        held = 1'b0;
        logic [63:0] held_res = '0;
        logic [3:0]  held_tag = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_ops = 0;
                held = 1'b0;
            end else begin
                if (held && rsp_valid) begin
                    check("rsp_hold_result", rsp_result, held_res);
                    check("rsp_hold_tag", 64'(rsp_tag), 64'(held_tag));
                end
                held = rsp_valid && !rsp_ready;
                held_res = rsp_result;
                held_tag = rsp_tag;
                if (cmd_valid && cmd_ready)
                    q.push_back(model(cmd_op, cmd_a, cmd_b, cmd_shamt, cmd_sub_start,
                                      cmd_sub_len, cmd_tag));
                if (rsp_valid && rsp_ready) begin
                    exp_ops++;
                    if (q.size() == 0) begin
                        check("unexpected_rsp", 64'(rsp_tag), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("rsp_result", rsp_result, e.res);
                        check("rsp_overflow", 64'(rsp_overflow), 64'(e.ov));
                        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh, input logic [5:0] st, input logic [5:0] len,
                        input logic [TAG_W-1:0] tag);
        int n;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh;
        cmd_sub_start = st; cmd_sub_len = len; cmd_tag = tag; cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(q.size()), 64'd0);
        check("drain_not_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, cyc, run, n;
        logic last_acc;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ops_done", 64'(ops_done), 64'd0);
        check("reset_alu_a", alu_a, 64'd0);
        check("reset_cmd_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // 1: ADD with carry out, accept-to-valid latency of two cycles
        rsp_ready = 1'b1;
        send(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 6'd0, 6'd0, 4'd3);
        cmd_valid = 1'b0;
        @(negedge clk); check("t1_valid_lat0", 64'(rsp_valid), 64'd0);
        @(negedge clk); check("t1_valid_lat1", 64'(rsp_valid), 64'd0);
        @(negedge clk); check("t1_valid_lat2", 64'(rsp_valid), 64'd1);
        @(negedge clk); check("t1_ops_done", 64'(ops_done), 64'd1);
        drain();

        // 2: four back-to-back ops, responses on consecutive cycles
        run = 0;
        fork
            begin
                send(OP_SUB, 64'd5, 64'd3, 6'd0, 6'd0, 6'd0, 4'd1);
                send(OP_GT, 64'd7, 64'd2, 6'd0, 6'd0, 6'd0, 4'd2);
                send(OP_SHL, 64'd1, 64'd0, 6'd63, 6'd0, 6'd0, 4'd3);
                send(OP_SUBSTR, 64'hAB, 64'hAB, 6'd0, 6'd4, 6'd4, 4'd4);
                cmd_valid = 1'b0;
            end
            begin
                n = 0;
                @(negedge clk);
                while (!rsp_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 4; k++) begin
                    if (rsp_valid) run++;
                    @(negedge clk);
                end
            end
        join
        check("t2_consecutive", 64'(run), 64'd4);
        drain();

        // 3: back-pressure fills credit, pop releases it one cycle later
        rsp_ready = 1'b0;
        acc = 0;
        cmd_op = OP_AND; cmd_a = 64'hFF00; cmd_b = 64'h0FF0; cmd_tag = 4'd8; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            last_acc = cmd_ready;
            if (last_acc) acc++;
            @(posedge clk); #1;
            if (last_acc) begin
                cmd_tag = cmd_tag + 4'd1;
                cmd_a = cmd_a + 64'h1111;
            end
        end
        check("t3_accepts", 64'(acc), 64'd4);
        @(negedge clk); check("t3_full_no_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk); check("t3_ready_same_cycle", 64'(cmd_ready), 64'd0);
        @(negedge clk); check("t3_ready_after_pop", 64'(cmd_ready), 64'd1);
        drain();

        // 4: unsupported op masked, then a normal OR
        send(4'b1100, 64'd1, 64'd1, 6'd5, 6'd0, 6'd0, 4'd5);
        send(OP_OR, 64'hF0, 64'h0F, 6'd0, 6'd0, 6'd0, 4'd6);
        cmd_valid = 1'b0;
        drain();

        // 5: reset with two ops in flight and one queued
        rsp_ready = 1'b0;
        send(OP_ADD, 64'd10, 64'd20, 6'd0, 6'd0, 6'd0, 4'd9);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        send(OP_SUB, 64'd9, 64'd4, 6'd0, 6'd0, 6'd0, 4'd10);
        send(OP_AND, 64'd3, 64'd6, 6'd0, 6'd0, 6'd0, 4'd11);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy_before", 64'(busy), 64'd1);
        check("t5_valid_before", 64'(rsp_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_alu_a", alu_a, 64'd0);
        check("t5_alu_op", 64'(alu_op_code), 64'd0);
        check("t5_alu_shamt", 64'(alu_shift_amt), 64'd0);
        check("t5_ops_done", 64'(ops_done), 64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(OP_XNOR, 64'd0, 64'd0, 6'd0, 6'd0, 6'd0, 4'd12);
        cmd_valid = 1'b0;
        drain();

        // 6: random ops with random back-pressure
        acc = 0; cyc = 0; last_acc = 1'b0;
        while (acc < 200 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (last_acc || !cmd_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    cmd_op = 4'($urandom_range(0, 15));
                    cmd_a = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom};
                    cmd_b = ($urandom_range(0, 3) == 0) ? 64'd31 : {$urandom, $urandom};
                    cmd_shamt = 6'($urandom);
                    cmd_sub_start = 6'($urandom);
                    cmd_sub_len = 6'($urandom);
                    cmd_tag = 4'($urandom);
                    cmd_valid = 1'b1;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            last_acc = cmd_valid && cmd_ready;
            if (last_acc) acc++;
        end
        check("t6_accept_count", 64'(acc), 64'd200);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();
        @(negedge clk);
        check("final_ops_done", 64'(ops_done), 64'(exp_ops));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
